// File: rtl/nus_pkg.sv
// Shared definitions for the sample packer: lump geometry, time-code type and nsamp decode.
package nus_pkg;

  localparam int unsigned NSAMP_W = 3;
  localparam int unsigned LANES   = 8;
  localparam int unsigned LUMP_W  = 75;

  typedef logic [8:0] tcode_t;

  // nsamp of zero encodes a full group of eight samples.
  function automatic logic [3:0] nsamp_decode(logic [NSAMP_W-1:0] nsamp);
    return (nsamp == '0) ? 4'd8 : {1'b0, nsamp};
  endfunction

endpackage

// File: rtl/nus_lane_compactor.sv
// Combinational next-buffer: drop popped entries off the front, append n new samples at base.
module nus_lane_compactor
  import nus_pkg::*;
#(
  parameter int unsigned word_size = 9,
  parameter int unsigned buf_depth = 16
) (
  input  logic [buf_depth*word_size-1:0] buf_cur,
  input  logic [3:0]                     popped,
  input  logic [4:0]                     base,
  input  logic [3:0]                     n,
  input  logic                           wr,
  input  logic [LANES*word_size-1:0]     samples,
  output logic [buf_depth*word_size-1:0] buf_nxt
);

  always_comb begin
    logic [4:0] src;
    logic [4:0] rel;
    buf_nxt = '0;
    src     = '0;
    rel     = '0;
    for (int i = 0; i < int'(buf_depth); i++) begin
      src = 5'(i) + {1'b0, popped};
      rel = 5'(i) - base;
      if (5'(i) < base) begin
        if (src < 5'(buf_depth)) begin
          buf_nxt[i*word_size +: word_size] = buf_cur[src*word_size +: word_size];
        end
      end else if (wr && (rel < {1'b0, n})) begin
        buf_nxt[i*word_size +: word_size] = samples[rel[2:0]*word_size +: word_size];
      end
      // Entries past the new fill level are left zero so stale codes never linger.
    end
  end

endmodule

// File: rtl/nus_sample_packer.sv
// Packs variable-length time-code groups into fixed 8-sample words on a valid/ready stream.
module nus_sample_packer
  import nus_pkg::*;
#(
  parameter int unsigned word_size = 9,
  parameter int unsigned buf_depth = 16,
  parameter int unsigned drop_w    = 8
) (
  input  logic                         clk_in,
  input  logic                         resetb,
  input  logic                         in_en,
  input  logic [LUMP_W-1:0]            in_word,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*word_size-1:0]   out_data,
  output logic [3:0]                   out_cnt,
  output logic [7:0]                   out_seq,
  output logic                         overflow,
  output logic [drop_w-1:0]            drop_cnt
);

  logic [buf_depth*word_size-1:0] buf_q, buf_d;
  logic [4:0]                     count_q, count_d;
  logic                           flush_pend_q, flush_pend_d;
  logic [7:0]                     seq_q, seq_d;
  logic                           overflow_q, overflow_d;
  logic [drop_w-1:0]              drop_q, drop_d;

  logic [3:0] n, popped;
  logic [4:0] base, space;
  logic       pop, push, drop;

  assign n = nsamp_decode(in_word[NSAMP_W-1:0]);

  always_comb begin
    out_cnt   = (count_q >= 5'd8) ? 4'd8 : count_q[3:0];
    out_valid = (count_q >= 5'd8) | (flush_pend_q & (count_q != 5'd0));
    out_data  = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (4'(k) < out_cnt) begin
        out_data[k*word_size +: word_size] = buf_q[k*word_size +: word_size];
      end
    end
  end

  // Pop is resolved first so a full buffer being drained can still accept a group.
  always_comb begin
    pop     = out_valid & out_ready;
    popped  = pop ? out_cnt : 4'd0;
    base    = count_q - {1'b0, popped};
    space   = 5'(buf_depth) - base;
    push    = in_en & ({1'b0, n} <= space);
    drop    = in_en & ~push;
    count_d = base + (push ? {1'b0, n} : 5'd0);

    flush_pend_d = (flush_pend_q & ~pop) | flush;
    seq_d        = pop ? seq_q + 8'd1 : seq_q;
    overflow_d   = overflow_q | drop;
    drop_d       = (drop && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
  end

  nus_lane_compactor #(
    .word_size (word_size),
    .buf_depth (buf_depth)
  ) u_compactor (
    .buf_cur (buf_q),
    .popped  (popped),
    .base    (base),
    .n       (n),
    .wr      (push),
    .samples (in_word[LUMP_W-1:NSAMP_W]),
    .buf_nxt (buf_d)
  );

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      buf_q        <= '0;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
      seq_q        <= '0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      buf_q        <= buf_d;
      count_q      <= count_d;
      flush_pend_q <= flush_pend_d;
      seq_q        <= seq_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
    end
  end

  assign out_seq  = seq_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_nus_sample_packer.sv
// Bench for nus_sample_packer: vector table, directed corner sequences and a queue-based random model.
module tb_nus_sample_packer;

  logic        clk_in = 1'b0;
  logic        resetb;
  logic        in_en;
  logic [74:0] in_word;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_data;
  logic [3:0]  out_cnt;
  logic [7:0]  out_seq;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  nus_sample_packer dut (
    .clk_in    (clk_in),
    .resetb    (resetb),
    .in_en     (in_en),
    .in_word   (in_word),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_seq   (out_seq),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit en;
    int nsamp;
    int base;
    bit fl;
    bit rdy;
    bit ev;
    int ecnt;
    int efirst;
    int eseq;
  } vec_t;

  vec_t tbl[13];

  // Reference model state: sample queue plus flags.
  int unsigned mq[$];
  bit          m_pend;
  int          m_seq;
  bit          m_ovf;
  int          m_drops;

  task automatic check(string name, logic [71:0] act, logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk(int first, int cnt);
    logic [71:0] r;
    r = '0;
    for (int k = 0; k < cnt; k++) r[9*k +: 9] = 9'(first + k);
    return r;
  endfunction

  function automatic logic [74:0] lump(int nsamp, int base);
    logic [74:0] w;
    for (int i = 0; i < 8; i++) w[3 + 9*i +: 9] = 9'(base + i);
    w[2:0] = 3'(nsamp);
    return w;
  endfunction

  task automatic drive(bit en, int nsamp, int base, bit fl, bit rdy);
    in_en     = en;
    in_word   = lump(nsamp, base);
    flush     = fl;
    out_ready = rdy;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    in_en     = 1'b0;
    in_word   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    resetb    = 1'b0;
    @(posedge clk_in);
    #1;
    resetb = 1'b1;
    mq.delete();
    m_pend  = 1'b0;
    m_seq   = 0;
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  task automatic check_zero(string tag);
    check({tag, " valid"}, out_valid, 0);
    check({tag, " cnt"},   out_cnt, 0);
    check({tag, " data"},  out_data, 0);
    check({tag, " seq"},   out_seq, 0);
    check({tag, " ovf"},   overflow, 0);
    check({tag, " drops"}, drop_cnt, 0);
  endtask

  // One cycle against the reference model, then compare every output.
  task automatic mstep(bit en, logic [74:0] w, bit fl, bit rdy);
    int sz, cnt, n;
    bit v;
    logic [71:0] ed;
    in_en     = en;
    in_word   = w;
    flush     = fl;
    out_ready = rdy;
    sz  = mq.size();
    cnt = (sz > 8) ? 8 : sz;
    v   = (sz >= 8) || (m_pend && sz > 0);
    @(posedge clk_in);
    #1;
    if (v && rdy) begin
      repeat (cnt) void'(mq.pop_front());
      m_seq  = (m_seq + 1) % 256;
      m_pend = 1'b0;
    end
    if (fl) m_pend = 1'b1;
    if (en) begin
      n = (w[2:0] == 3'd0) ? 8 : int'(w[2:0]);
      if (n <= 16 - mq.size()) begin
        for (int i = 0; i < n; i++) mq.push_back(int'(w[3 + 9*i +: 9]));
      end else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    sz  = mq.size();
    cnt = (sz > 8) ? 8 : sz;
    ed  = '0;
    for (int k = 0; k < cnt; k++) ed[9*k +: 9] = 9'(mq[k]);
    check("rnd valid", out_valid, ((sz >= 8) || (m_pend && sz > 0)) ? 1 : 0);
    check("rnd cnt",   out_cnt, cnt);
    check("rnd data",  out_data, ed);
    check("rnd seq",   out_seq, m_seq);
    check("rnd ovf",   overflow, m_ovf);
    check("rnd drops", drop_cnt, m_drops);
  endtask

  initial begin
    tbl[0]  = '{1, 3, 1,  0, 1, 0, 3, 1,  0};
    tbl[1]  = '{1, 5, 4,  0, 1, 1, 8, 1,  0};
    tbl[2]  = '{0, 0, 0,  0, 1, 0, 0, 0,  1};
    tbl[3]  = '{1, 5, 10, 0, 1, 0, 5, 10, 1};
    tbl[4]  = '{0, 0, 0,  1, 1, 1, 5, 10, 1};
    tbl[5]  = '{0, 0, 0,  0, 1, 0, 0, 0,  2};
    tbl[6]  = '{1, 6, 20, 0, 0, 0, 6, 20, 2};
    tbl[7]  = '{0, 0, 0,  1, 0, 1, 6, 20, 2};
    tbl[8]  = '{1, 0, 30, 0, 1, 1, 8, 30, 3};
    tbl[9]  = '{0, 0, 0,  0, 1, 0, 0, 0,  4};
    tbl[10] = '{0, 0, 0,  1, 1, 0, 0, 0,  4};
    tbl[11] = '{1, 2, 40, 0, 1, 1, 2, 40, 4};
    tbl[12] = '{0, 0, 0,  0, 1, 0, 0, 0,  5};

    resetb    = 1'b0;
    in_en     = 1'b0;
    in_word   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #3;
    check_zero("reset");
    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].nsamp, tbl[i].base, tbl[i].fl, tbl[i].rdy);
      check($sformatf("vec%0d valid", i), out_valid, tbl[i].ev);
      check($sformatf("vec%0d cnt", i),   out_cnt, tbl[i].ecnt);
      check($sformatf("vec%0d data", i),  out_data, mk(tbl[i].efirst, tbl[i].ecnt));
      check($sformatf("vec%0d seq", i),   out_seq, tbl[i].eseq);
    end
    check("vec ovf", overflow, 0);

    // Full-rate streaming: one word per cycle with consecutive sequence numbers.
    do_reset();
    for (int j = 0; j < 20; j++) begin
      drive(1, 0, 8*j, 0, 1);
      check($sformatf("stream%0d valid", j), out_valid, 1);
      check($sformatf("stream%0d seq", j),   out_seq, j);
      check($sformatf("stream%0d data", j),  out_data, mk(8*j, 8));
    end
    drive(0, 0, 0, 0, 1);
    check("stream end valid", out_valid, 0);
    check("stream end seq",   out_seq, 20);
    check("stream ovf",       overflow, 0);

    // Stall: fill to 16, third group dropped, presented word frozen.
    drive(1, 0, 100, 0, 0);
    check("stall1 data", out_data, mk(100, 8));
    drive(1, 0, 108, 0, 0);
    check("stall2 data", out_data, mk(100, 8));
    check("stall2 ovf",  overflow, 0);
    drive(1, 0, 116, 0, 0);
    check("stall3 data",  out_data, mk(100, 8));
    check("stall3 ovf",   overflow, 1);
    check("stall3 drops", drop_cnt, 1);
    drive(0, 0, 0, 0, 1);
    check("drain1 data", out_data, mk(108, 8));
    check("drain1 seq",  out_seq, 21);
    drive(0, 0, 0, 0, 1);
    check("drain2 valid", out_valid, 0);
    check("drain2 seq",   out_seq, 22);

    // Asynchronous reset in the middle of a stall with twelve samples buffered.
    drive(1, 0, 200, 0, 0);
    drive(1, 4, 208, 0, 0);
    check("prerst data", out_data, mk(200, 8));
    resetb = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk_in);
    #1;
    resetb = 1'b1;
    drive(1, 0, 300, 0, 1);
    check("postrst valid", out_valid, 1);
    check("postrst data",  out_data, mk(300, 8));
    check("postrst seq",   out_seq, 0);
    drive(0, 0, 0, 0, 1);
    check("postrst empty cnt", out_cnt, 0);

    // Randomized traffic against the queue model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [74:0] w;
      for (int i = 0; i < 75; i += 25) w[i +: 25] = 25'($urandom);
      mstep(($urandom_range(0, 3) != 0), w, ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0));
    end

    // Saturate the drop counter under a permanent stall.
    for (int c = 0; c < 262; c++) mstep(1, lump(0, c), 0, 0);
    check("drop saturate", drop_cnt, 8'hff);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
